// File: rtl/spart_pkg.sv
// Shared definitions for the SPART keyboard-event front end: byte field
// positions, default sizing and the decoded-event record.
package spart_pkg;

    localparam int SPART_REL_BIT   = 7;
    localparam int SPART_IDX_W     = 7;
    localparam int SPART_KEY_W_DEF = 13;
    localparam int SPART_DEPTH_DEF = 8;

    // One received byte split into its fields; valid mirrors rx_valid.
    typedef struct packed {
        logic                   valid;
        logic                   rel;
        logic [SPART_IDX_W-1:0] idx;
    } spart_evt_t;

    // Split a received byte into release flag and key index.
    function automatic spart_evt_t spart_decode(input logic valid, input logic [7:0] data);
        spart_evt_t e;
        e.valid = valid;
        e.rel   = data[SPART_REL_BIT];
        e.idx   = data[SPART_IDX_W-1:0];
        return e;
    endfunction

endpackage

// File: rtl/spart_key_fifo.sv
// Synchronous FIFO of key masks. The head word is captured into an output
// register on pop (registered RAM read), so the parent sees the popped entry
// on the cycle after the pop edge. A push while full is accepted only when a
// pop happens on the same edge; otherwise it is dropped and reported.
module spart_key_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd_data_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_next;
    logic              pop_ok;
    logic              push_ok;

    assign full    = (fill_reg == FILL_W'(DEPTH));
    assign empty   = (fill_reg == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;

    assign rd_data = rd_data_reg;
    assign wr_ptr  = wr_ptr_reg;
    assign rd_ptr  = rd_ptr_reg;
    assign fill    = fill_reg;

    // Occupancy follows the accepted push/pop pair.
    always_comb begin
        fill_next = fill_reg;
        case ({push_ok, pop_ok})
            2'b10:   fill_next = fill_reg + FILL_W'(1);
            2'b01:   fill_next = fill_reg - FILL_W'(1);
            default: fill_next = fill_reg;
        endcase
    end

    // Storage write; no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Registered head read; a same-edge write to this slot returns the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (pop_ok) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); fill tracks the difference.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            fill_reg <= fill_next;
        end
    end

endmodule

// File: rtl/spart_key_queue.sv
// Keyboard-event front end: decodes SPART bytes into a held-key mask, queues
// every mask change and hands each one to the CPU as a one-cycle SPART_we
// pulse, spaced by MIN_GAP idle cycles and gated by cpu_rdy.
// Optional auto-repeat of the held mask: define SPART_KEY_REPEAT_EN.
module spart_key_queue
    import spart_pkg::*;
#(
    parameter int KEY_W      = SPART_KEY_W_DEF,
    parameter int DEPTH      = SPART_DEPTH_DEF,
    parameter int MIN_GAP    = 0,
    parameter int REPEAT_CYC = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   cpu_rdy,
    output logic                   SPART_we,
    output logic [KEY_W-1:0]       SPART_keys,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   overflow,
    output logic                   bad_code
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    spart_evt_t        evt;
    logic              idx_ok;
    logic              bad_evt;
    logic [KEY_W-1:0]  mask_reg;
    logic [KEY_W-1:0]  mask_next;
    logic              byte_push;
    logic              push;
    logic [KEY_W-1:0]  push_data;
    logic              pop;
    logic              drop;
    logic [GAP_W-1:0]  gap_reg;
    logic              we_reg;
    logic              overflow_reg;
    logic              bad_code_reg;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W-1:0]  fifo_wr_ptr;
    logic [PTR_W-1:0]  fifo_rd_ptr;

    assign evt     = spart_decode(rx_valid, rx_data);
    assign idx_ok  = evt.valid && (int'(evt.idx) < KEY_W);
    assign bad_evt = evt.valid && !idx_ok;

    // Each mask bit is rewritten only when the byte names it.
    generate
        for (genvar gi = 0; gi < KEY_W; gi++) begin : g_mask_bit
            assign mask_next[gi] = (idx_ok && (evt.idx == SPART_IDX_W'(gi))) ? ~evt.rel
                                                                              : mask_reg[gi];
        end
    endgenerate

    // Duplicate presses and releases of unheld keys leave the mask alone.
    assign byte_push = (mask_next != mask_reg);

`ifdef SPART_KEY_REPEAT_EN
    localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

    logic [REP_W-1:0] rep_cnt_reg;
    logic             rep_fire;

    // A byte that changes the mask clears the counter, so the two push sources never collide.
    assign rep_fire  = !byte_push && (mask_reg != '0) &&
                       (rep_cnt_reg == REP_W'(REPEAT_CYC - 1));
    assign push      = byte_push || rep_fire;
    assign push_data = byte_push ? mask_next : mask_reg;

    // Count quiet cycles while keys are held; restart on any change or repeat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt_reg <= '0;
        end else if (byte_push || (mask_reg == '0) || rep_fire) begin
            rep_cnt_reg <= '0;
        end else begin
            rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
        end
    end
`else
    assign push      = byte_push;
    assign push_data = mask_next;
`endif

    // Delivery decision from start-of-cycle state only; an entry pushed this edge waits a cycle.
    assign pop = !fifo_empty && (gap_reg == '0) && cpu_rdy;

    spart_key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .rd_data   (SPART_keys),
        .wr_ptr    (fifo_wr_ptr),
        .rd_ptr    (fifo_rd_ptr),
        .fill      (fill),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (drop)
    );

    // Held-key mask follows every accepted byte, even when its queue entry is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_reg <= '0;
        end else begin
            mask_reg <= mask_next;
        end
    end

    // Gap counter reloads on each pulse and drains regardless of cpu_rdy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_reg <= '0;
        end else if (pop) begin
            gap_reg <= GAP_W'(MIN_GAP);
        end else if (gap_reg != '0) begin
            gap_reg <= gap_reg - GAP_W'(1);
        end
    end

    // Strobe and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_reg       <= 1'b0;
            overflow_reg <= 1'b0;
            bad_code_reg <= 1'b0;
        end else begin
            we_reg       <= pop;
            overflow_reg <= overflow_reg | drop;
            bad_code_reg <= bad_code_reg | bad_evt;
        end
    end

    assign SPART_we = we_reg;
    assign overflow = overflow_reg;
    assign bad_code = bad_code_reg;

    // Legal parameter space: mask width fits the 7-bit index, depth is a power of two.
    param_sane: assert property (@(posedge clk)
        (KEY_W >= 1) && (KEY_W <= 127) && (DEPTH >= 2) &&
        ((DEPTH & (DEPTH - 1)) == 0) && (REPEAT_CYC >= 1) && (MIN_GAP >= 0));

    // Pointer distance always equals occupancy modulo DEPTH.
    ptr_fill_match: assert property (@(posedge clk) disable iff (!rst_n)
        PTR_W'(fifo_wr_ptr - fifo_rd_ptr) == fill[PTR_W-1:0]);

    // A full queue has its pointers meeting.
    full_ptrs_meet: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full |-> (fifo_wr_ptr == fifo_rd_ptr));

endmodule
